div_rate_sched: RTL and testbench
=================================

Name: div_rate_sched

Overview:
- Owns the divided-rate timebase for the design and schedules rate changes requested by several clients (e.g. RSA core, UI/switch logic).
- Emits a single-cycle clock-enable `tick` at period 2^(cur_sel+1) clk cycles, rather than a derived clock.
- Arbitrates rate-change requests round-robin and applies each change only at a period boundary, so no truncated or runt period ever reaches consumers.

Parameters:
- NREQ, 2, number of requesters.
- CW, 32, free-running counter width.
- SELW, 5, width of a rate select.
- DEFAULT_SEL, 20, cur_sel value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  per-requester rate-change request; held until ack.
- req_sel  in  NREQ*SELW  requested select; slice i belongs to requester i.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse when a granted select is >= CW (rejected).
- cur_sel  out  SELW  select currently in force.
- tick  out  1  one-cycle enable pulse, period 2^(cur_sel+1).
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values: cnt=0, cur_sel=DEFAULT_SEL, tick=0, ack=0, err=0, busy=0, state=IDLE, rr_ptr=0.
- Reset mid-operation aborts any pending change; no ack is issued for it.
- Counter: cnt increments by 1 every cycle and wraps at 2^CW. Its only other write is the reset to 0 on APPLY entry.
- Boundary: mask = (2<<cur_sel)-1, computed CW+1 bits wide. bnd = ((cnt & mask) == mask).
- tick is registered: tick <= bnd. It is therefore high the cycle after cnt hits the boundary.
- FSM states: IDLE, WAIT, APPLY, ERR.
- IDLE:
  - If any req is high, grant the first requester at or after rr_ptr (cyclic) and latch g_idx and g_sel.
  - g_sel >= CW -> ERR.
  - g_sel == cur_sel -> APPLY, with no counter reset and no cur_sel change.
  - Otherwise -> WAIT.
- WAIT:
  - Hold until bnd. On that edge: cur_sel <= g_sel, cnt <= 0, -> APPLY.
  - The tick for the completing old period still fires on this edge.
- APPLY: ack[g_idx] <= 1 for exactly one cycle; rr_ptr <= (g_idx+1) mod NREQ; -> IDLE.
- ERR: err <= 1 and ack[g_idx] <= 1 for one cycle; cur_sel and cnt are unchanged; rr_ptr advances; -> IDLE.
- Latching rules:
  - The request is latched at grant. A later req drop or req_sel change does not affect the pending change, and the ack is still issued.
  - A requester still holding req in the cycle after its ack is treated as a new request.
- Arbitration:
  - Simultaneous requests: rr_ptr order; req0 wins the first arbitration after reset.
  - Only one change is in flight at a time. Other requesters wait in IDLE arbitration.
- Worst case: cur_sel=31 gives a WAIT of up to 2^32 cycles. This is accepted; busy reflects it.
- ack/err are registered, so at most one ack bit is high in any cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/WAIT/APPLY/ERR);
  - SELW and CW defaults;
  - a function sel_mask(sel) returning the CW+1-bit period mask.
- One natural sub-module: rr_arbiter. Inputs are NREQ request bits and rr_ptr; outputs are a one-hot grant plus grant index. It is purely combinational, with rr_ptr kept in the parent.
- Counter, tick and FSM stay in div_rate_sched.

Test Plan (bench uses DEFAULT_SEL=2, NREQ=2, CW=32):
- Reset release, no requests:
  - first tick high after the 8th clk edge, then every 8 cycles;
  - cur_sel=2, busy=0, ack=0.
- req0=1, sel=0 raised when cnt=3:
  - busy next cycle;
  - the cnt=7 boundary tick still fires;
  - cur_sel=0, cnt=0 on that edge, ack[0] one cycle later;
  - ticks then every 2 cycles.
- req0 (sel=4) and req1 (sel=1) raised on the same cycle after reset:
  - req0 is granted first and acked;
  - req1 is then granted, ending with cur_sel=1;
  - next simultaneous pair grants req1 first.
- req1 with sel == cur_sel:
  - ack[1] two cycles after req;
  - cnt is not reset and the tick phase is unchanged.
- Instance with CW=16, req0 sel=20:
  - err and ack[0] pulse together;
  - cur_sel and tick cadence are unchanged.
- rst asserted while in WAIT:
  - all outputs go to reset values immediately and asynchronously;
  - no ack is issued;
  - cur_sel=DEFAULT_SEL.

Source files
------------

// File: rtl/div_rate_sched_pkg.sv
// Shared types, default widths and the period-mask helper for the divided-rate scheduler.
package div_rate_sched_pkg;

  localparam int unsigned SelW  = 5;
  localparam int unsigned CntW  = 32;
  localparam int unsigned MaskW = 64;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StApply,
    StErr
  } state_e;

  // Low (sel+1) bits set: a period of 2^(sel+1) cycles ends when cnt has all of them high.
  function automatic logic [MaskW-1:0] sel_mask(input int unsigned sel);
    return (MaskW'(2) << sel) - MaskW'(1);
  endfunction

endpackage

// File: rtl/div_rate_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, cyclically.
module div_rate_sched_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  int unsigned       idx;
  logic [IdxW-1:0]   idx_w;
  logic              found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IdxW'(idx);
      if (!found && req_i[idx_w]) begin
        found        = 1'b1;
        gnt_o[idx_w] = 1'b1;
        gnt_idx_o    = idx_w;
      end
    end
  end

endmodule

// File: rtl/div_rate_sched.sv
// Divided-rate timebase: emits a tick every 2^(cur_sel+1) cycles and applies
// round-robin-arbitrated rate changes only at period boundaries.
module div_rate_sched
  import div_rate_sched_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned CW          = CntW,
  parameter int unsigned SELW        = SelW,
  parameter int unsigned DEFAULT_SEL = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SELW-1:0] req_sel,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [SELW-1:0]      cur_sel,
  output logic                 tick,
  output logic                 busy
);

  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MaskCw = CW + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic [SELW-1:0] g_sel_q, g_sel_d;
  logic [IdxW-1:0] g_idx_q, g_idx_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            tick_q, tick_d;

  logic [NREQ-1:0] gnt;
  logic [IdxW-1:0] gnt_idx;
  logic [SELW-1:0] gnt_sel;
  logic [SELW-1:0] sel_arr [NREQ];
  logic [CW:0]     mask;
  logic            bnd;
  logic [IdxW-1:0] next_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_sel_slice
    assign sel_arr[i] = req_sel[i*SELW +: SELW];
  end

  div_rate_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // One-hot AND-OR mux of the granted requester's select.
  always_comb begin
    gnt_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_sel = gnt_sel | sel_arr[i];
    end
  end

  assign mask     = MaskCw'(sel_mask(32'(cur_sel_q)));
  assign bnd      = (({1'b0, cnt_q} & mask) == mask);
  assign next_ptr = (g_idx_q == IdxW'(NREQ - 1)) ? '0 : g_idx_q + IdxW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    cur_sel_d = cur_sel_q;
    g_sel_d   = g_sel_q;
    g_idx_d   = g_idx_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    err_d     = 1'b0;
    tick_d    = bnd;
    case (state_q)
      StIdle: begin
        if (|gnt) begin
          g_idx_d = gnt_idx;
          g_sel_d = gnt_sel;
          if (32'(gnt_sel) >= CW) begin
            state_d = StErr;
          end else if (gnt_sel == cur_sel_q) begin
            state_d = StApply;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // The old period's final tick still fires on this edge via tick_d = bnd.
        if (bnd) begin
          cur_sel_d = g_sel_q;
          cnt_d     = '0;
          state_d   = StApply;
        end
      end
      StApply: begin
        ack_d[g_idx_q] = 1'b1;
        rr_ptr_d       = next_ptr;
        state_d        = StIdle;
      end
      StErr: begin
        err_d          = 1'b1;
        ack_d[g_idx_q] = 1'b1;
        rr_ptr_d       = next_ptr;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cur_sel_q <= SELW'(DEFAULT_SEL);
      g_sel_q   <= '0;
      g_idx_q   <= '0;
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      g_sel_q   <= g_sel_d;
      g_idx_q   <= g_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tick_q    <= tick_d;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign cur_sel = cur_sel_q;
  assign tick    = tick_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_div_rate_sched.sv
// Scoreboard bench for div_rate_sched: expected acks are queued at stimulus time and
// popped by a negedge monitor; tick cadence and reset behaviour are checked directly.
module tb_div_rate_sched;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [4:0]  sel;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = '0;
  logic [9:0] req_sel = '0;
  logic [1:0] ack;
  logic       err;
  logic [4:0] cur_sel;
  logic       tick;
  logic       busy;

  logic [1:0] r16_req = '0;
  logic [9:0] r16_req_sel = '0;
  logic [1:0] r16_ack;
  logic       r16_err;
  logic [4:0] r16_cur_sel;
  logic       r16_tick;
  logic       r16_busy;

  int unsigned cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q_main[$];
  exp_t        q16[$];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  div_rate_sched #(
    .NREQ        (2),
    .CW          (32),
    .SELW        (5),
    .DEFAULT_SEL (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_sel (req_sel),
    .ack     (ack),
    .err     (err),
    .cur_sel (cur_sel),
    .tick    (tick),
    .busy    (busy)
  );

  div_rate_sched #(
    .NREQ        (2),
    .CW          (16),
    .SELW        (5),
    .DEFAULT_SEL (2)
  ) dut16 (
    .clk     (clk),
    .rst     (rst),
    .req     (r16_req),
    .req_sel (r16_req_sel),
    .ack     (r16_ack),
    .err     (r16_err),
    .cur_sel (r16_cur_sel),
    .tick    (r16_tick),
    .busy    (r16_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] a, input logic e, input logic [4:0] s,
                              input int unsigned c);
    exp_t r;
    r.ack = a;
    r.err = e;
    r.sel = s;
    r.cyc = c;
    return r;
  endfunction

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every ack/err presented by either instance must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ack !== 2'b00 || err !== 1'b0)) begin
      if (q_main.size() == 0) begin
        chk("main unexpected ack/err", {29'd0, err, ack}, 32'd0);
      end else begin
        e = q_main.pop_front();
        chk("main ack", {30'd0, ack}, {30'd0, e.ack});
        chk("main err", {31'd0, err}, {31'd0, e.err});
        chk("main cur_sel at ack", {27'd0, cur_sel}, {27'd0, e.sel});
        chk("main ack cycle", cyc, e.cyc);
      end
    end
    if (!rst && (r16_ack !== 2'b00 || r16_err !== 1'b0)) begin
      if (q16.size() == 0) begin
        chk("cw16 unexpected ack/err", {29'd0, r16_err, r16_ack}, 32'd0);
      end else begin
        e = q16.pop_front();
        chk("cw16 ack", {30'd0, r16_ack}, {30'd0, e.ack});
        chk("cw16 err", {31'd0, r16_err}, {31'd0, e.err});
        chk("cw16 cur_sel at ack", {27'd0, r16_cur_sel}, {27'd0, e.sel});
        chk("cw16 ack cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("reset cur_sel", {27'd0, cur_sel}, 32'd2);
    chk("reset tick", {31'd0, tick}, 32'd0);
    chk("reset ack", {30'd0, ack}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free-running cadence: tick after edge 8, 16, 24
    for (int unsigned c = 1; c <= 24; c++) begin
      wait_cyc(c);
      chk("idle tick cadence", {31'd0, tick}, {31'd0, (c % 8) == 0});
    end
    chk("idle busy", {31'd0, busy}, 32'd0);

    // req0 sel=0 raised when cnt=27 (3 mod 8)
    wait_cyc(27);
    req[0] = 1'b1;
    req_sel[4:0] = 5'd0;
    q_main.push_back(mk(2'b01, 1'b0, 5'd0, 33));
    wait_cyc(28);
    chk("busy after grant", {31'd0, busy}, 32'd1);
    wait_cyc(31);
    chk("no tick before boundary", {31'd0, tick}, 32'd0);
    wait_cyc(32);
    chk("old-period boundary tick", {31'd0, tick}, 32'd1);
    chk("cur_sel switched", {27'd0, cur_sel}, 32'd0);
    wait_cyc(33);
    req[0] = 1'b0;
    for (int unsigned c = 34; c <= 40; c++) begin
      wait_cyc(c);
      chk("sel0 tick cadence", {31'd0, tick}, {31'd0, (c % 2) == 0});
    end

    // Simultaneous requests after reset: req0 first
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);
    req = 2'b11;
    req_sel = {5'd1, 5'd4};
    q_main.push_back(mk(2'b01, 1'b0, 5'd4, 9));
    q_main.push_back(mk(2'b10, 1'b0, 5'd1, 41));
    wait_cyc(2);
    chk("pair busy", {31'd0, busy}, 32'd1);
    wait_cyc(8);
    chk("pair first switch tick", {31'd0, tick}, 32'd1);
    chk("pair first cur_sel", {27'd0, cur_sel}, 32'd4);
    wait_cyc(9);
    req[0] = 1'b0;
    wait_cyc(40);
    chk("pair second switch tick", {31'd0, tick}, 32'd1);
    wait_cyc(41);
    req[1] = 1'b0;
    chk("pair final cur_sel", {27'd0, cur_sel}, 32'd1);

    // req1 with sel == cur_sel: fast ack, counter phase untouched
    wait_cyc(43);
    req[1] = 1'b1;
    req_sel[9:5] = 5'd1;
    q_main.push_back(mk(2'b10, 1'b0, 5'd1, 45));
    for (int unsigned c = 44; c <= 52; c++) begin
      wait_cyc(c);
      if (c == 45) req[1] = 1'b0;
      chk("same-sel tick phase", {31'd0, tick}, {31'd0, (c % 4) == 0});
    end

    // req0 alone moves rr_ptr to 1; the next pair then grants req1 first
    wait_cyc(53);
    req[0] = 1'b1;
    req_sel[4:0] = 5'd1;
    q_main.push_back(mk(2'b01, 1'b0, 5'd1, 55));
    wait_cyc(55);
    req[0] = 1'b0;
    wait_cyc(56);
    req = 2'b11;
    req_sel = {5'd1, 5'd1};
    q_main.push_back(mk(2'b10, 1'b0, 5'd1, 58));
    q_main.push_back(mk(2'b01, 1'b0, 5'd1, 60));
    wait_cyc(58);
    req[1] = 1'b0;
    wait_cyc(60);
    req[0] = 1'b0;

    // CW=16 instance: sel=20 rejected, cadence untouched
    for (int unsigned c = 60; c <= 72; c++) begin
      wait_cyc(c);
      if (c == 61) begin
        r16_req[0] = 1'b1;
        r16_req_sel[4:0] = 5'd20;
        q16.push_back(mk(2'b01, 1'b1, 5'd2, 63));
      end
      if (c == 63) r16_req[0] = 1'b0;
      chk("cw16 tick cadence", {31'd0, r16_tick}, {31'd0, (c % 8) == 0});
    end
    chk("cw16 cur_sel kept", {27'd0, r16_cur_sel}, 32'd2);
    chk("cw16 idle after err", {31'd0, r16_busy}, 32'd0);

    // Asynchronous reset while in WAIT
    wait_cyc(73);
    req[0] = 1'b1;
    req_sel[4:0] = 5'd5;
    wait_cyc(74);
    chk("wait busy before reset", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset cur_sel", {27'd0, cur_sel}, 32'd2);
    chk("async reset ack", {30'd0, ack}, 32'd0);
    chk("async reset err", {31'd0, err}, 32'd0);
    chk("async reset tick", {31'd0, tick}, 32'd0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post-reset cur_sel", {27'd0, cur_sel}, 32'd2);
    chk("post-reset busy", {31'd0, busy}, 32'd0);

    chk("main queue drained", q_main.size(), 32'd0);
    chk("cw16 queue drained", q16.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
